// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state type and decode helpers for alu_iter_muldiv
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_REM   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_REMU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SEQ   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Any divide/remainder flavour
    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // Ops that normally go through the multi-cycle core
    function automatic logic is_iter(input logic [3:0] op);
        return is_div(op) || (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    // Signed divide/remainder (need magnitude conversion and sign fix-up)
    function automatic logic is_sdiv(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// rtl/alu_iter_core.sv - shared shift/add-sub datapath for shift-add multiply and restoring divide
module alu_iter_core #(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            start,
    input  logic            div_mode,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            last,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);

    localparam int STEPS = XLEN / STEP_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    // hi: partial product high half / partial remainder
    // lo: multiplier being shifted out / dividend shifting into quotient
    logic [XLEN-1:0] hi, lo, m;
    logic            dv;
    logic            busy;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] nxt_hi, nxt_lo;

    // One retired bit; a single adder serves both the multiply add and the divide trial subtract
    function automatic logic [2*XLEN-1:0] one_step(input logic [XLEN-1:0] h,
                                                   input logic [XLEN-1:0] l,
                                                   input logic [XLEN-1:0] mm,
                                                   input logic            d);
        logic [XLEN:0]   opx, opy;
        logic            cin;
        logic [XLEN+1:0] full;
        if (d) begin
            opx = {h, l[XLEN-1]};
            opy = ~{1'b0, mm};
            cin = 1'b1;
        end else begin
            opx = {1'b0, h};
            opy = l[0] ? {1'b0, mm} : '0;
            cin = 1'b0;
        end
        full = {1'b0, opx} + {1'b0, opy} + {{(XLEN+1){1'b0}}, cin};
        if (d) begin
            // carry out of the subtract means the trial remainder did not go negative
            if (full[XLEN+1])
                return {full[XLEN-1:0], l[XLEN-2:0], 1'b1};
            else
                return {opx[XLEN-1:0], l[XLEN-2:0], 1'b0};
        end
        return {full[XLEN:1], full[0], l[XLEN-1:1]};
    endfunction

    // Chain STEP_BITS single-bit steps within one cycle
    always_comb begin
        nxt_hi = hi;
        nxt_lo = lo;
        for (int i = 0; i < STEP_BITS; i++) begin
            {nxt_hi, nxt_lo} = one_step(nxt_hi, nxt_lo, m, dv);
        end
    end

    assign last   = busy && (cnt == CW'(1));
    assign res_hi = nxt_hi;
    assign res_lo = nxt_lo;

    // Operand load on start, then one step per cycle until the count runs out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            m    <= '0;
            dv   <= 1'b0;
        end else if (kill) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(STEPS);
            dv   <= div_mode;
            hi   <= '0;
            lo   <= div_mode ? src_a : src_b;
            m    <= div_mode ? src_b : src_a;
        end else if (busy) begin
            hi  <= nxt_hi;
            lo  <= nxt_lo;
            cnt <= cnt - CW'(1);
            if (last)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - ALU with single-cycle base ops and iterative mul/div behind valid/ready
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            carry_out,
    output logic            overflow,
    output logic            zero
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt;
    logic            accept, go_iter;
    logic            div_by0, div_ovf, sdiv;
    logic            a_neg, b_neg;
    logic [XLEN:0]   add_full;
    logic [XLEN-1:0] sub_res;
    logic [XLEN-1:0] imm_res, fin_res;
    logic            imm_c, imm_v;
    logic [3:0]      op_q;
    logic            neg_q, neg_r;
    logic            core_last;
    logic [XLEN-1:0] core_hi, core_lo;

    assign accept   = in_valid && in_ready && !flush;
    assign a_neg    = a_in[XLEN-1];
    assign b_neg    = b_in[XLEN-1];
    assign sdiv     = is_sdiv(alu_sel);
    assign div_by0  = is_div(alu_sel) && (b_in == '0);
    assign div_ovf  = sdiv && (a_in == MIN_VAL) && (&b_in);
    assign go_iter  = accept && is_iter(alu_sel) && !div_by0 && !div_ovf;
    assign add_full = {1'b0, a_in} + {1'b0, b_in};
    assign sub_res  = a_in - b_in;

    alu_iter_core #(
        .XLEN      (XLEN),
        .STEP_BITS (STEP_BITS)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .kill     (flush),
        .start    (go_iter),
        .div_mode (is_div(alu_sel)),
        .src_a    ((sdiv && a_neg) ? -a_in : a_in),
        .src_b    ((sdiv && b_neg) ? -b_in : b_in),
        .last     (core_last),
        .res_hi   (core_hi),
        .res_lo   (core_lo)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: flush wins from any state
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = go_iter ? BUSY : DONE;
                BUSY:    if (core_last) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Single-cycle results, including the div special cases that skip iteration
    always_comb begin
        imm_res = '0;
        imm_c   = 1'b0;
        imm_v   = 1'b0;
        case (alu_sel)
            OP_AND: imm_res = a_in & b_in;
            OP_OR:  imm_res = a_in | b_in;
            OP_NOR: imm_res = ~(a_in | b_in);
            OP_SEQ: imm_res = {{(XLEN-1){1'b0}}, a_in == b_in};
            OP_SLT: imm_res = {{(XLEN-1){1'b0}}, $signed(a_in) < $signed(b_in)};
            OP_ADD: begin
                imm_res = add_full[XLEN-1:0];
                imm_c   = add_full[XLEN];
                imm_v   = (a_neg == b_neg) && (add_full[XLEN-1] != a_neg);
            end
            OP_SUB: begin
                imm_res = sub_res;
                imm_v   = (a_neg != b_neg) && (sub_res[XLEN-1] != a_neg);
            end
            OP_DIV, OP_DIVU: begin
                if (div_by0) begin
                    imm_res = '1;
                end else if (div_ovf) begin
                    imm_res = MIN_VAL;
                    imm_v   = 1'b1;
                end
            end
            OP_REM, OP_REMU: if (div_by0) imm_res = a_in;
            default: ;
        endcase
    end

    // Select the core half and apply sign fix-up for signed divide/remainder
    always_comb begin
        case (op_q)
            OP_MUL:   fin_res = core_lo;
            OP_MULHU: fin_res = core_hi;
            OP_DIV:   fin_res = neg_q ? -core_lo : core_lo;
            OP_REM:   fin_res = neg_r ? -core_hi : core_hi;
            OP_REMU:  fin_res = core_hi;
            default:  fin_res = core_lo;
        endcase
    end

    // Latch opcode and result signs at accept; operands are held inside the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_AND;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            op_q  <= alu_sel;
            neg_q <= sdiv && (a_neg ^ b_neg);
            neg_r <= sdiv && a_neg;
        end
    end

    // Result registers; flags always travel with the value they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out   <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else if (flush) begin
            alu_out   <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else if (accept && !go_iter) begin
            alu_out   <= imm_res;
            carry_out <= imm_c;
            overflow  <= imm_v;
            zero      <= (imm_res == '0);
        end else if ((state == BUSY) && core_last) begin
            alu_out   <= fin_res;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= (fin_res == '0);
        end
    end

endmodule

// File: tb/tb_alu_iter_muldiv.sv
// tb/tb_alu_iter_muldiv.sv - scoreboard bench: 32-bit/1-step and 16-bit/2-step instances vs arithmetic model
module tb_alu_iter_muldiv;

    typedef struct {
        int          id;
        logic [63:0] res;
        logic        c;
        logic        v;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv  [2];
    logic        fl  [2];
    logic        ord [2];
    logic [3:0]  sel [2];
    logic [63:0] av  [2];
    logic [63:0] bv  [2];
    wire  [1:0]  ir, ovd, co, vo, zo;
    wire  [31:0] r0;
    wire  [15:0] r1;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   drv_done = 0;
    exp_t q [$];
    exp_t cur [2];
    bit   seen [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_iter_muldiv #(.XLEN(32), .STEP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .alu_sel(sel[0]), .a_in(av[0][31:0]), .b_in(bv[0][31:0]), .out_valid(ovd[0]),
        .out_ready(ord[0]), .alu_out(r0), .carry_out(co[0]), .overflow(vo[0]), .zero(zo[0])
    );

    alu_iter_muldiv #(.XLEN(16), .STEP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .alu_sel(sel[1]), .a_in(av[1][15:0]), .b_in(bv[1][15:0]), .out_valid(ovd[1]),
        .out_ready(ord[1]), .alu_out(r1), .carry_out(co[1]), .overflow(vo[1]), .zero(zo[1])
    );

    function automatic logic [63:0] rsel(input int d);
        return d ? {48'd0, r1} : {32'd0, r0};
    endfunction

    function automatic logic [63:0] wmask(input int d);
        return d ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands at the instance's width
    function automatic exp_t model(input int d, input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        exp_t        e;
        int          w    = d ? 16 : 32;
        int          step = d ? 2 : 1;
        int          it   = 1 + w / step;
        logic [63:0] m    = wmask(d);
        logic [63:0] a    = x & m;
        logic [63:0] b    = y & m;
        logic [64:0] s65;
        longint      sa, sb, s;
        longint      minv = -(longint'(1) << (w - 1));
        longint      maxv = (longint'(1) << (w - 1)) - 1;
        sa = longint'(a);
        if (a[w-1]) sa -= longint'(1) << w;
        sb = longint'(b);
        if (b[w-1]) sb -= longint'(1) << w;
        e.id = d; e.res = 64'd0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b) & m;
            4'b1111: e.res = (a == b) ? 64'd1 : 64'd0;
            4'b0111: e.res = (sa < sb) ? 64'd1 : 64'd0;
            4'b0010: begin
                s65   = {1'b0, a} + {1'b0, b};
                e.res = s65[63:0] & m;
                e.c   = s65[w];
                s     = sa + sb;
                e.v   = (s > maxv) || (s < minv);
            end
            4'b0110: begin
                e.res = (a - b) & m;
                s     = sa - sb;
                e.v   = (s > maxv) || (s < minv);
            end
            4'b1000: begin e.res = (a * b) & m;  e.lat = it; end
            4'b1001: begin e.res = (a * b) >> w; e.lat = it; end
            4'b0011: begin
                if (b == 0) e.res = m;
                else if (sa == minv && sb == -1) begin e.res = a; e.v = 1'b1; end
                else begin e.res = m & 64'(sa / sb); e.lat = it; end
            end
            4'b0100: begin
                if (b == 0) e.res = a;
                else if (sa == minv && sb == -1) e.res = 64'd0;
                else begin e.res = m & 64'(sa % sb); e.lat = it; end
            end
            4'b1010: begin
                if (b == 0) e.res = m;
                else begin e.res = a / b; e.lat = it; end
            end
            4'b1011: begin
                if (b == 0) e.res = a;
                else begin e.res = a % b; e.lat = it; end
            end
            default: e.res = 64'd0;
        endcase
        e.z = (e.res == 64'd0);
        return e;
    endfunction

    function automatic int pending(input int d);
        int n = 0;
        foreach (q[i]) if (q[i].id == d) n++;
        return n;
    endfunction

    // Discard the outstanding expectation of an instance whose op was killed
    task automatic drop(input int d);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].id == d) begin
                q.delete(i);
                return;
            end
        end
    endtask

    // Wait for in_ready, present one op for one edge, record the expectation
    task automatic send(input int d, input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        exp_t e;
        int   n = 0;
        while (!ir[d] && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ir[d]) begin
            n_vec++;
            n_bad++;
            $display("FAIL dut%0d in_ready timeout", d);
            return;
        end
        sel[d] = op;
        av[d]  = x & wmask(d);
        bv[d]  = y & wmask(d);
        iv[d]  = 1'b1;
        @(posedge clk); #1;
        e     = model(d, op, x, y);
        e.acc = cyc;
        q.push_back(e);
        iv[d] = 1'b0;
        av[d] = {$urandom, $urandom};
        bv[d] = {$urandom, $urandom};
    endtask

    function automatic logic [63:0] rnd_opnd(input int d);
        int w = d ? 16 : 32;
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return wmask(d);
            2: return 64'd1 << (w - 1);
            3: return 64'($urandom_range(0, 9));
            4: return (64'd1 << (w - 1)) - 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: first sighting of out_valid pops the expectation and checks latency;
    // values are rechecked every cycle the result is held
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (ovd[d]) begin
                    if (!seen[d]) begin
                        int idx;
                        idx = -1;
                        foreach (q[i]) if (idx < 0 && q[i].id == d) idx = i;
                        if (idx < 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL dut%0d unexpected out_valid, alu_out=%h", d, rsel(d));
                        end else begin
                            cur[d]  = q[idx];
                            q.delete(idx);
                            seen[d] = 1'b1;
                            chk($sformatf("dut%0d latency", d), 64'(cyc - cur[d].acc), 64'(cur[d].lat - 1));
                        end
                    end
                    if (seen[d]) begin
                        chk($sformatf("dut%0d alu_out", d),   rsel(d),     cur[d].res);
                        chk($sformatf("dut%0d carry_out", d), 64'(co[d]),  64'(cur[d].c));
                        chk($sformatf("dut%0d overflow", d),  64'(vo[d]),  64'(cur[d].v));
                        chk($sformatf("dut%0d zero", d),      64'(zo[d]),  64'(cur[d].z));
                    end
                    if (ord[d]) seen[d] = 1'b0;
                end else begin
                    seen[d] = 1'b0;
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, " out_valid"}, 64'(ovd[0]), 64'd0);
        chk({tag, " alu_out"},   rsel(0),     64'd0);
        chk({tag, " carry"},     64'(co[0]),  64'd0);
        chk({tag, " overflow"},  64'(vo[0]),  64'd0);
        chk({tag, " zero"},      64'(zo[0]),  64'd1);
        chk({tag, " in_ready"},  64'(ir[0]),  64'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; fl[d] = 1'b0; ord[d] = 1'b1;
            sel[d] = 4'd0; av[d] = 64'd0; bv[d] = 64'd0;
            seen[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset in_ready", 64'(ir[0]), 64'd1);

        // Directed boundary vectors on the 32-bit instance
        send(0, 4'b0010, 64'h7FFF_FFFF, 64'h1);
        send(0, 4'b1000, 64'hFFFF_FFFF, 64'h2);
        send(0, 4'b1001, 64'hFFFF_FFFF, 64'h2);
        send(0, 4'b0011, 64'hFFFF_FFF9, 64'h2);
        send(0, 4'b0100, 64'hFFFF_FFF9, 64'h2);
        send(0, 4'b1010, 64'd100, 64'd0);
        send(0, 4'b1011, 64'd100, 64'd0);
        send(0, 4'b0011, 64'h8000_0000, 64'hFFFF_FFFF);
        send(0, 4'b0100, 64'h8000_0000, 64'hFFFF_FFFF);
        send(0, 4'b0010, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        send(0, 4'b0110, 64'h8000_0000, 64'h1);
        send(0, 4'b0111, 64'hFFFF_FFFF, 64'h1);
        send(0, 4'b1101, 64'h1234, 64'h5678);

        // Backpressure: hold the DIVU result for 5 cycles
        @(posedge clk); #1;
        ord[0] = 1'b0;
        send(0, 4'b1010, 64'd1000, 64'd7);
        n = 0;
        while (!ovd[0] && n < 100) begin @(posedge clk); #1; n++; end
        chk("bp out_valid reached", 64'(ovd[0]), 64'd1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp in_ready low", 64'(ir[0]), 64'd0);
            chk("bp out_valid held", 64'(ovd[0]), 64'd1);
        end
        ord[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp consume in_ready", 64'(ir[0]), 64'd1);
        chk("bp consume out_valid", 64'(ovd[0]), 64'd0);

        // Flush at BUSY cycle 10; the result must never appear
        send(0, 4'b1000, {$urandom, $urandom}, {$urandom, $urandom});
        repeat (9) @(posedge clk);
        #1 fl[0] = 1'b1;
        drop(0);
        @(posedge clk); #1;
        fl[0] = 1'b0;
        chk("flush in_ready", 64'(ir[0]), 64'd1);
        chk("flush out_valid", 64'(ovd[0]), 64'd0);
        repeat (40) @(posedge clk);
        #1 send(0, 4'b0110, 64'd5, 64'd5);

        // Flush together with in_valid: no accept
        @(posedge clk); #1;
        while (!ir[0]) begin @(posedge clk); #1; end
        sel[0] = 4'b0010; av[0] = 64'd1; bv[0] = 64'd1; iv[0] = 1'b1; fl[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0; fl[0] = 1'b0;
        chk("flush+valid in_ready", 64'(ir[0]), 64'd1);
        chk("flush+valid out_valid", 64'(ovd[0]), 64'd0);
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of a multiply
        #1 send(0, 4'b1000, 64'hDEAD_BEEF, 64'h1234_5678);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        drop(0);
        #1 chk_reset_vals("async reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized regression on both instances with random backpressure
        fork
            begin
                for (int i = 0; i < 120; i++)
                    send(0, 4'($urandom_range(0, 15)), rnd_opnd(0), rnd_opnd(0));
                drv_done++;
            end
            begin
                for (int i = 0; i < 400; i++)
                    send(1, 4'($urandom_range(0, 15)), rnd_opnd(1), rnd_opnd(1));
                drv_done++;
            end
            begin
                n = 0;
                while (drv_done < 2 && n < 40000) begin
                    @(posedge clk); #1;
                    ord[0] = ($urandom_range(0, 3) != 0);
                    ord[1] = ($urandom_range(0, 3) != 0);
                    n++;
                end
                ord[0] = 1'b1;
                ord[1] = 1'b1;
            end
        join

        n = 0;
        while ((q.size() != 0 || seen[0] || seen[1]) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard drained", 64'(q.size()), 64'd0);
        chk("dut0 outstanding", 64'(pending(0)), 64'd0);
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
